// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: packed-BCD adder/subtractor, one decimal digit per clock, LSD first.
// Latency: DIGITS+1 cycles from the accepting edge to the one-cycle done pulse.
// Backpressure: none; start is honoured only in IDLE, otherwise dropped (no queuing).
// Optional macro BCD_INVALID_CHECK_EN enables the captured-operand nibble>9 check on err.
module bcd_serial_addsub #(
   parameter  int DIGITS = 4,
   localparam int W      = 4 * DIGITS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] d,
   output logic         cout,
   output logic         err
);

   // Digit index width: ceil(log2(DIGITS)), at least one bit.
   localparam int            KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  d_q, d_d;
   logic [KW-1:0] k_q, k_d;
   logic          sub_q, sub_d;
   logic          c_q, c_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          cout_q, cout_d;
   logic          err_q, err_d;

   // Digit datapath signals for the digit currently addressed by k.
   logic [3:0]    a_dig;
   logic [3:0]    b_dig;
   logic [3:0]    b_eff;
   logic [4:0]    t_sum;
   logic          dig_carry;
   logic [3:0]    res_dig;
   logic          bad_in;

`ifdef BCD_INVALID_CHECK_EN
   // True when any nibble of the operand is outside 0..9.
   function automatic logic any_invalid(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         bad = bad | (v[i*4 +: 4] > 4'd9);
      end
      return bad;
   endfunction

   // Validity check over the operands being captured at start.
   always_comb begin
      bad_in = any_invalid(a) | any_invalid(b);
   end
`else
   // Check disabled: err is tied low, arithmetic unaffected.
   always_comb begin
      bad_in = 1'b0;
   end
`endif

   // Select digit k of the captured operands.
   always_comb begin
      a_dig = 4'd0;
      b_dig = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (k_q == KW'(i)) begin
            a_dig = a_q[i*4 +: 4];
            b_dig = b_q[i*4 +: 4];
         end
      end
   end

   // Single decimal-correcting digit adder; subtract uses nine's complement
   // of b with the initial carry set, giving A + (10^N - 1 - B) + 1.
   always_comb begin
      b_eff     = sub_q ? (4'd9 - b_dig) : b_dig;
      t_sum     = {1'b0, a_dig} + {1'b0, b_eff} + {4'd0, c_q};
      dig_carry = (t_sum >= 5'd10);
      res_dig   = dig_carry ? (t_sum[3:0] + 4'd6) : t_sum[3:0];
   end

   // Next-state and next-output logic for the IDLE/CALC/DONE sequencer.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      d_d     = d_q;
      k_d     = k_q;
      sub_d   = sub_q;
      c_d     = c_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cout_d  = cout_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sub_d   = sub;
               k_d     = '0;
               c_d     = sub;
               d_d     = '0;
               cout_d  = 1'b0;
               err_d   = bad_in;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (k_q == KW'(i)) begin
                  d_d[i*4 +: 4] = res_dig;
               end
            end
            c_d = dig_carry;
            if (k_q == K_LAST) begin
               // Last digit: flag completion; k is not advanced past the top digit.
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cout_d  = sub_q ? ~dig_carry : dig_carry;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         k_q     <= '0;
         sub_q   <= 1'b0;
         c_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         d_q     <= d_d;
         k_q     <= k_d;
         sub_q   <= sub_d;
         c_q     <= c_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign d    = d_q;
   assign cout = cout_q;
   assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: DIGITS=4, 1 and 8 instances on one clock.
// Expected results come from decimal integer arithmetic on the operands.
// Inputs driven #1 after the rising edge; outputs sampled at the same point.
module tb_bcd_serial_addsub;

`ifdef BCD_INVALID_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        st4 = 0, sb4 = 0, busy4, done4, cout4, err4;
   logic [15:0] a4 = '0, b4 = '0, d4;
   logic        st1 = 0, sb1 = 0, busy1, done1, cout1, err1;
   logic [3:0]  a1 = '0, b1 = '0, d1;
   logic        st8 = 0, sb8 = 0, busy8, done8, cout8, err8;
   logic [31:0] a8 = '0, b8 = '0, d8;

   bcd_serial_addsub #(.DIGITS(4)) u4 (.clk(clk), .rst_n(rst_n), .start(st4), .sub(sb4),
      .a(a4), .b(b4), .busy(busy4), .done(done4), .d(d4), .cout(cout4), .err(err4));
   bcd_serial_addsub #(.DIGITS(1)) u1 (.clk(clk), .rst_n(rst_n), .start(st1), .sub(sb1),
      .a(a1), .b(b1), .busy(busy1), .done(done1), .d(d1), .cout(cout1), .err(err1));
   bcd_serial_addsub #(.DIGITS(8)) u8 (.clk(clk), .rst_n(rst_n), .start(st8), .sub(sb8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .d(d8), .cout(cout8), .err(err8));

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input int inst, input logic s, input logic sb,
                        input logic [31:0] av, input logic [31:0] bv);
      case (inst)
         1: begin st1 = s; sb1 = sb; a1 = av[3:0];  b1 = bv[3:0];  end
         8: begin st8 = s; sb8 = sb; a8 = av;       b8 = bv;       end
         default: begin st4 = s; sb4 = sb; a4 = av[15:0]; b4 = bv[15:0]; end
      endcase
   endtask

   function automatic logic get_done(input int inst);
      case (inst)
         1: return done1;
         8: return done8;
         default: return done4;
      endcase
   endfunction

   function automatic logic [31:0] get_d(input int inst);
      case (inst)
         1: return {28'd0, d1};
         8: return d8;
         default: return {16'd0, d4};
      endcase
   endfunction

   function automatic logic get_cout(input int inst);
      case (inst)
         1: return cout1;
         8: return cout8;
         default: return cout4;
      endcase
   endfunction

   function automatic logic get_err(input int inst);
      case (inst)
         1: return err1;
         8: return err8;
         default: return err4;
      endcase
   endfunction

   // Reference model: decimal integers, not digit-serial.
   function automatic longint bcd2int(input logic [31:0] v, input int n);
      longint r = 0;
      for (int i = n - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [31:0] int2bcd(input longint x, input int n);
      logic [31:0] r = '0;
      longint y = x;
      for (int i = 0; i < n; i++) begin
         r[i*4 +: 4] = 4'(y % 10);
         y = y / 10;
      end
      return r;
   endfunction

   task automatic model(input logic s, input logic [31:0] av, input logic [31:0] bv,
                        input int n, output logic [31:0] dv, output logic cv);
      longint m = 1;
      longint r;
      for (int i = 0; i < n; i++) m = m * 10;
      if (!s) begin
         r  = bcd2int(av, n) + bcd2int(bv, n);
         cv = (r >= m);
         dv = int2bcd(r % m, n);
      end else begin
         r  = bcd2int(av, n) - bcd2int(bv, n);
         cv = (r < 0);
         if (r < 0) r = r + m;
         dv = int2bcd(r, n);
      end
   endtask

   function automatic logic [31:0] rand_bcd(input int n);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
      return r;
   endfunction

   // One operation: start for one cycle, wait for done (bounded), then
   // confirm done drops after a single cycle and the result is held.
   task automatic run_op(input int inst, input logic s, input logic [31:0] av,
                         input logic [31:0] bv, output logic [31:0] dv,
                         output logic cv, output logic ev, output int lat);
      drive(inst, 1'b1, s, av, bv);
      @(posedge clk); #1;
      drive(inst, 1'b0, s, av, bv);
      lat = 1;
      while (!get_done(inst) && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      dv = get_d(inst);
      cv = get_cout(inst);
      ev = get_err(inst);
      @(posedge clk); #1;
      check("done_one_cycle", {31'd0, get_done(inst)}, 32'd0);
      check("d_hold", get_d(inst), dv);
   endtask

   typedef struct {
      logic        s;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] d;
      logic        c;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [31:0] dv, exp_d;
      logic        cv, ev, exp_c;
      int          lat, n, inst, cnt, first, prev;
      logic [31:0] ra, rb;
      logic        rs;

      vecs[0] = '{1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0};
      vecs[1] = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1};
      vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      vecs[3] = '{1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0};
      vecs[4] = '{1'b1, 16'h0123, 16'h0456, 16'h9667, 1'b1};
      vecs[5] = '{1'b1, 16'h4321, 16'h4321, 16'h0000, 1'b0};
      vecs[6] = '{1'b0, 16'h0500, 16'h0500, 16'h1000, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy4}, 32'd0);
      check("rst_done", {31'd0, done4}, 32'd0);
      check("rst_d", {16'd0, d4}, 32'd0);
      check("rst_cout", {31'd0, cout4}, 32'd0);
      check("rst_err", {31'd0, err4}, 32'd0);
      check("rst_d8", d8, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table, DIGITS=4
      for (int i = 0; i < 7; i++) begin
         run_op(4, vecs[i].s, {16'd0, vecs[i].a}, {16'd0, vecs[i].b}, dv, cv, ev, lat);
         check("tbl_d", dv, {16'd0, vecs[i].d});
         check("tbl_cout", {31'd0, cv}, {31'd0, vecs[i].c});
         check("tbl_err", {31'd0, ev}, 32'd0);
         check("tbl_lat", lat, 32'd5);
      end

      // Invalid nibble: err depends on build, done still pulses exactly once
      run_op(4, 1'b0, 32'h00A0, 32'h0001, dv, cv, ev, lat);
      check("inv_err", {31'd0, ev}, {31'd0, CHK});
      check("inv_lat", lat, 32'd5);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done4) cnt++;
      end
      check("inv_extra_done", cnt, 32'd0);

      // Start during CALC is ignored
      drive(4, 1'b1, 1'b0, 32'h1234, 32'h5678);
      @(posedge clk); #1;
      drive(4, 1'b1, 1'b1, 32'h1111, 32'h1111);
      @(posedge clk); #1;
      drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
      lat = 2;
      while (!done4 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("ign_d", {16'd0, d4}, 32'h6912);
      check("ign_lat", lat, 32'd5);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done4) cnt++;
      end
      check("ign_no_second", cnt, 32'd0);

      // Start held high: one done every DIGITS+2 cycles
      drive(4, 1'b1, 1'b0, 32'h1234, 32'h5678);
      cnt = 0; first = -1; prev = -1;
      for (int c = 1; c <= 26; c++) begin
         @(posedge clk); #1;
         if (c == 20) drive(4, 1'b0, 1'b0, 32'h1234, 32'h5678);
         if (done4) begin
            cnt++;
            if (first < 0) first = c;
            else check("held_period", c - prev, 32'd6);
            prev = c;
         end
      end
      check("held_first", first, 32'd5);
      check("held_count", cnt, 32'd4);
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-operation
      drive(4, 1'b1, 1'b0, 32'h1234, 32'h5678);
      @(posedge clk); #1;
      drive(4, 1'b0, 1'b0, 32'h1234, 32'h5678);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_busy_before", {31'd0, busy4}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy4}, 32'd0);
      check("abort_done", {31'd0, done4}, 32'd0);
      check("abort_d", {16'd0, d4}, 32'd0);
      check("abort_cout", {31'd0, cout4}, 32'd0);
      check("abort_err", {31'd0, err4}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done4) cnt++;
      end
      check("abort_no_done", cnt, 32'd0);
      run_op(4, 1'b0, 32'h1234, 32'h5678, dv, cv, ev, lat);
      check("post_abort_d", dv, 32'h6912);
      check("post_abort_lat", lat, 32'd5);

      // DIGITS=1
      run_op(1, 1'b0, 32'h4, 32'h8, dv, cv, ev, lat);
      check("d1_d", dv, 32'h2);
      check("d1_cout", {31'd0, cv}, 32'd1);
      check("d1_lat", lat, 32'd2);
      run_op(1, 1'b1, 32'h3, 32'h7, dv, cv, ev, lat);
      check("d1_sub_d", dv, 32'h6);
      check("d1_sub_cout", {31'd0, cv}, 32'd1);

      // DIGITS=8
      run_op(8, 1'b0, 32'h00001234, 32'h00005678, dv, cv, ev, lat);
      check("d8_d", dv, 32'h00006912);
      check("d8_cout", {31'd0, cv}, 32'd0);
      check("d8_lat", lat, 32'd9);
      run_op(8, 1'b1, 32'h00000000, 32'h00000001, dv, cv, ev, lat);
      check("d8_sub_d", dv, 32'h99999999);
      check("d8_sub_cout", {31'd0, cv}, 32'd1);

      // Randomized operations against the decimal model
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: begin inst = 8; n = 8; end
            1: begin inst = 1; n = 1; end
            default: begin inst = 4; n = 4; end
         endcase
         ra = rand_bcd(n);
         rb = rand_bcd(n);
         rs = 1'($urandom_range(0, 1));
         model(rs, ra, rb, n, exp_d, exp_c);
         run_op(inst, rs, ra, rb, dv, cv, ev, lat);
         check("rnd_d", dv, exp_d);
         check("rnd_cout", {31'd0, cv}, {31'd0, exp_c});
         check("rnd_lat", lat, n + 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_serial_addsub.md
# bcd_serial_addsub

Parametrised multi-digit packed-BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first, through a single 4-bit decimal-correcting digit adder. It generalises the combinational two-digit BCD adder to DIGITS digits, adds a subtract mode, a start/done handshake and input-digit validity checking. It serves as the arithmetic core for BCD counters, calculators and display datapaths in the lab designs.

## Interface

- DIGITS, 4, number of BCD digits per operand (≥1); operand width W = 4*DIGITS
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request an operation; sampled only in IDLE
- sub  input  1  0 = A+B, 1 = A−B; captured with start
- a  input  W  operand A, packed BCD, digit 0 in a[3:0]; captured with start
- b  input  W  operand B, packed BCD; captured with start
- busy  output  1  high while an operation is in progress (CALC)
- done  output  1  one-cycle pulse, result valid
- d  output  W  result, packed BCD; held until the next start
- cout  output  1  add: decimal carry out; sub: borrow (1 when A<B)
- err  output  1  any captured nibble of a or b > 9

## Operation

- States: IDLE, CALC, DONE.
- IDLE: busy=0. On start=1: capture a, b and sub into internal registers, clear digit index k to 0, set carry c = sub, clear d, set err per validity check, go to CALC.
- CALC: each cycle, process digit k: b' = sub ? (9 − b_k) : b_k (nine's complement, 4-bit); t = a_k + b' + c, 5 bits (max 19). If t ≥ 10, digit = (t + 6)[3:0] and c = 1; otherwise digit = t[3:0] and c = 0. Write the digit to d[4k+3:4k] and increment k. After digit DIGITS−1, go to DONE.
- DONE: done=1 for exactly one cycle; cout = sub ? ~c : c; return to IDLE.
- Subtract with A<B: d = ten's complement (10^DIGITS − (B−A)), cout=1.
- Invalid nibbles (> 9) are still processed by the same formula; the result is deterministic but not meaningful; err flags the condition.
- start while busy or in DONE is ignored; no queuing.
- d, cout and err hold their values from DONE until the next accepted start.

## Timing

- Reset values: state=IDLE, busy=0, done=0, d=0, cout=0, err=0, k=0, c=0.
- start accepted on edge E0; busy=1 from E0 through the end of CALC; the digit k result is registered at edge E0+k+1.
- done=1 in the cycle after edge E0+DIGITS; total latency is DIGITS+1 cycles from the accepting edge to the done pulse. Back-to-back operations need at least DIGITS+2 cycles each.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- If rst_n is asserted mid-operation, all registers return to reset values immediately. The aborted operation produces no done pulse.
- k is sized ceil(log2(DIGITS)), minimum 1 bit; there is no wrap beyond DIGITS−1.

## Configuration

- BCD_INVALID_CHECK_EN defined: err is the registered OR of (nibble > 9) over all captured a and b digits, evaluated at start.
- Not defined: the check logic is omitted and err is tied to 0. The port remains present and the arithmetic is unchanged.

## Test plan

- DIGITS=4, add 0x1234 + 0x5678 -> done 5 cycles after start, d=0x6912, cout=0, err=0.
- Add 0x9999 + 0x0001 -> d=0x0000, cout=1; add 0x0000 + 0x0000 -> d=0x0000, cout=0.
- Sub 0x5000 − 0x1234 -> d=0x3766, cout=0; sub 0x0123 − 0x0456 -> d=0x9667, cout=1; sub 0x4321 − 0x4321 -> d=0x0000, cout=0.
- a=0x00A0, b=0x0001, add -> err=1 with BCD_INVALID_CHECK_EN, err=0 without; done still pulses once.
- Pulse start again on the cycle after acceptance with different operands -> ignored, result reflects the first operands; hold start high for 20 cycles -> one done pulse every 6 cycles.
- Assert rst_n low 2 cycles after start -> busy, done, d, cout and err = 0 immediately, no done pulse; the next start completes normally. Repeat the 1234+5678 case with DIGITS=1 (operands 0x4 + 0x8 -> d=0x2, cout=1, latency 2 cycles) and with DIGITS=8.
